can_reg_read_mux: RTL and testbench

- Read-path register multiplexer between the host controller and the CAN core. It is the counterpart of the write-path demux.
- It decodes a controller read request (CS plus 8-bit address), selects one CAN core status word or RX FIFO word, and returns it on a registered data bus with an ack handshake.
- It pops the RX FIFO once per completed read of the last RX data word.

---
 rtl/can_regmap_pkg.sv | 21 ++
 rtl/can_reg_read_decode.sv | 40 ++++
 rtl/can_reg_read_mux.sv | 116 +++++++++++
 tb/tb_can_reg_read_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/can_regmap_pkg.sv
// CAN register map shared by the read mux and the write demux,
// plus the read-path FSM state encoding.
package can_regmap_pkg;

  localparam logic [7:0] ADDR_ECR        = 8'h10;
  localparam logic [7:0] ADDR_ESR        = 8'h14;
  localparam logic [7:0] ADDR_SR         = 8'h18;
  localparam logic [7:0] ADDR_ISR        = 8'h1C;
  localparam logic [7:0] ADDR_RXFIFO_ID  = 8'h50;
  localparam logic [7:0] ADDR_RXFIFO_DLC = 8'h54;
  localparam logic [7:0] ADDR_RXFIFO_DW1 = 8'h58;
  localparam logic [7:0] ADDR_RXFIFO_DW2 = 8'h5C;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_SELECT  = 2'd1,
    RD_ACK     = 2'd2,
    RD_RELEASE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/can_reg_read_decode.sv
// Combinational read decode: exact-match address to one register word,
// flagging unmapped addresses and RX reads while the FIFO is empty.
module can_reg_read_decode
  import can_regmap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] err_count,
  input  logic [DATA_W-1:0] err_status,
  input  logic [DATA_W-1:0] status,
  input  logic [DATA_W-1:0] interrupt_status,
  input  logic [DATA_W-1:0] rxfifo_id,
  input  logic [DATA_W-1:0] rxfifo_dlc,
  input  logic [DATA_W-1:0] rxfifo_dataword1,
  input  logic [DATA_W-1:0] rxfifo_dataword2,
  input  logic              rxfifo_empty,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (addr)
      ADDR_W'(ADDR_ECR): rd_data = err_count;
      ADDR_W'(ADDR_ESR): rd_data = err_status;
      ADDR_W'(ADDR_SR):  rd_data = status;
      ADDR_W'(ADDR_ISR): rd_data = interrupt_status;
      // An empty FIFO has no valid head word, so RX reads error out.
      ADDR_W'(ADDR_RXFIFO_ID):  if (rxfifo_empty) rd_err = 1'b1; else rd_data = rxfifo_id;
      ADDR_W'(ADDR_RXFIFO_DLC): if (rxfifo_empty) rd_err = 1'b1; else rd_data = rxfifo_dlc;
      ADDR_W'(ADDR_RXFIFO_DW1): if (rxfifo_empty) rd_err = 1'b1; else rd_data = rxfifo_dataword1;
      ADDR_W'(ADDR_RXFIFO_DW2): if (rxfifo_empty) rd_err = 1'b1; else rd_data = rxfifo_dataword2;
      default: rd_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/can_reg_read_mux.sv
// Controller read-path mux: CS/ack handshake over the CAN core status and
// RX FIFO words, popping the FIFO once per completed last-data-word read.
module can_reg_read_mux
  import can_regmap_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RX_POP_ADDR = ADDR_W'(8'h5C)
) (
  input  logic              sys_clk,
  input  logic              IP2Can_reset,
  input  logic              Controller2MUX_CS,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] Can2MUX_err_count,
  input  logic [DATA_W-1:0] Can2MUX_err_status,
  input  logic [DATA_W-1:0] Can2MUX_status,
  input  logic [DATA_W-1:0] Can2MUX_interrupt_status,
  input  logic [DATA_W-1:0] Can2MUX_rxfifo_id,
  input  logic [DATA_W-1:0] Can2MUX_rxfifo_dlc,
  input  logic [DATA_W-1:0] Can2MUX_rxfifo_dataword1,
  input  logic [DATA_W-1:0] Can2MUX_rxfifo_dataword2,
  input  logic              Can2MUX_rxfifo_empty,
  output logic [DATA_W-1:0] MUX2Controller_data,
  output logic              MUX2Controller_ack,
  output logic              MUX2Controller_err,
  output logic              MUX2rxfifo_rd
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;

  logic [DATA_W-1:0] dec_data;
  logic              dec_err;

  can_reg_read_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_decode (
    .addr             (addr_q),
    .err_count        (Can2MUX_err_count),
    .err_status       (Can2MUX_err_status),
    .status           (Can2MUX_status),
    .interrupt_status (Can2MUX_interrupt_status),
    .rxfifo_id        (Can2MUX_rxfifo_id),
    .rxfifo_dlc       (Can2MUX_rxfifo_dlc),
    .rxfifo_dataword1 (Can2MUX_rxfifo_dataword1),
    .rxfifo_dataword2 (Can2MUX_rxfifo_dataword2),
    .rxfifo_empty     (Can2MUX_rxfifo_empty),
    .rd_data          (dec_data),
    .rd_err           (dec_err)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        data_d = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        if (Controller2MUX_CS) begin
          addr_d  = addr_bus;
          state_d = RD_SELECT;
        end
      end
      RD_SELECT: begin
        data_d  = dec_data;
        err_d   = dec_err;
        ack_d   = 1'b1;
        // dec_err already covers the empty-FIFO case, so a pop never
        // accompanies an error response.
        rd_d    = (addr_q == RX_POP_ADDR) && !dec_err;
        state_d = RD_ACK;
      end
      RD_ACK: begin
        if (!Controller2MUX_CS) begin
          data_d  = '0;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = RD_RELEASE;
        end
      end
      RD_RELEASE: state_d = RD_IDLE;
      default:    state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge IP2Can_reset) begin
    if (IP2Can_reset) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign MUX2Controller_data = data_q;
  assign MUX2Controller_ack  = ack_q;
  assign MUX2Controller_err  = err_q;
  assign MUX2rxfifo_rd       = rd_q;

endmodule

// File: tb/tb_can_reg_read_mux.sv
// Bench for can_reg_read_mux: vector table, handshake corner sequences and
// randomized reads against a register-map reference model.
module tb_can_reg_read_mux;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [7:0]  addr;
  logic [31:0] regs [8];
  logic        empty;
  logic [31:0] data;
  logic        ack, err, rd;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0;

  logic [7:0] map_addr [8] = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h50, 8'h54, 8'h58, 8'h5C};

  always #5 sys_clk = ~sys_clk;

  can_reg_read_mux dut (
    .sys_clk                  (sys_clk),
    .IP2Can_reset             (rst),
    .Controller2MUX_CS        (cs),
    .addr_bus                 (addr),
    .Can2MUX_err_count        (regs[0]),
    .Can2MUX_err_status       (regs[1]),
    .Can2MUX_status           (regs[2]),
    .Can2MUX_interrupt_status (regs[3]),
    .Can2MUX_rxfifo_id        (regs[4]),
    .Can2MUX_rxfifo_dlc       (regs[5]),
    .Can2MUX_rxfifo_dataword1 (regs[6]),
    .Can2MUX_rxfifo_dataword2 (regs[7]),
    .Can2MUX_rxfifo_empty     (empty),
    .MUX2Controller_data      (data),
    .MUX2Controller_ack       (ack),
    .MUX2Controller_err       (err),
    .MUX2rxfifo_rd            (rd)
  );

  always @(negedge sys_clk) if (rd === 1'b1) pop_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: look the address up in the register map; RX words need a non-empty FIFO.
  function automatic logic [32:0] ref_read(input logic [7:0] a, input logic e);
    for (int i = 0; i < 8; i++)
      if (map_addr[i] == a) return (i >= 4 && e) ? {1'b1, 32'h0} : {1'b0, regs[i]};
    return {1'b1, 32'h0};
  endfunction

  task automatic set_fixed_regs();
    regs[0] = 32'h0000_0011; regs[1] = 32'h0000_0002;
    regs[2] = 32'hA5A5_0003; regs[3] = 32'h0000_0080;
    regs[4] = 32'h0000_0123; regs[5] = 32'h0000_0008;
    regs[6] = 32'hDEAD_BEEF; regs[7] = 32'hCAFE_F00D;
  endtask

  // One full CS transaction; scrambles the inputs during ACK to prove they were sampled in SELECT.
  task automatic read_check(input logic [7:0] a, input int hold, input logic [31:0] exp_data,
                            input logic exp_err, input logic exp_pop, input string tag);
    int lat;
    int p0;
    logic [31:0] d0;
    logic [31:0] saved [8];
    logic stable;
    saved = regs;
    @(posedge sys_clk); #1;
    cs = 1'b1; addr = a; p0 = pop_cnt; lat = 0;
    do begin @(posedge sys_clk); #1; lat++; end while (ack !== 1'b1 && lat < 10);
    chk({tag, " latency"}, lat, 2);
    chk({tag, " data"}, data, exp_data);
    chk({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, " rd_first"}, {31'h0, rd}, {31'h0, exp_pop});
    d0 = data; stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      for (int r = 0; r < 8; r++) regs[r] = $urandom;
      @(posedge sys_clk); #1;
      if (ack !== 1'b1 || data !== d0 || rd !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, " hold_stable"}, {31'h0, stable}, 32'h1);
    regs = saved;
    cs = 1'b0;
    @(posedge sys_clk); #1;
    chk({tag, " clear"}, {ack, err, data[29:0]} | {31'h0, |data[31:30]}, 32'h0);
    chk({tag, " pops"}, pop_cnt - p0, {31'h0, exp_pop});
  endtask

  typedef struct {
    logic [7:0]  a;
    logic        e;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_pop;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{8'h18, 1'b0, 0,  32'hA5A5_0003, 1'b0, 1'b0};
    vecs[1]  = '{8'h50, 1'b0, 1,  32'h0000_0123, 1'b0, 1'b0};
    vecs[2]  = '{8'h54, 1'b0, 0,  32'h0000_0008, 1'b0, 1'b0};
    vecs[3]  = '{8'h58, 1'b0, 2,  32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[4]  = '{8'h5C, 1'b0, 0,  32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[5]  = '{8'h5C, 1'b1, 1,  32'h0,         1'b1, 1'b0};
    vecs[6]  = '{8'h28, 1'b0, 0,  32'h0,         1'b1, 1'b0};
    vecs[7]  = '{8'h11, 1'b0, 0,  32'h0,         1'b1, 1'b0};
    vecs[8]  = '{8'h10, 1'b0, 0,  32'h0000_0011, 1'b0, 1'b0};
    vecs[9]  = '{8'h14, 1'b0, 1,  32'h0000_0002, 1'b0, 1'b0};
    vecs[10] = '{8'h1C, 1'b0, 0,  32'h0000_0080, 1'b0, 1'b0};
    vecs[11] = '{8'h50, 1'b1, 0,  32'h0,         1'b1, 1'b0};
    vecs[12] = '{8'h5C, 1'b0, 10, 32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[13] = '{8'h00, 1'b0, 0,  32'h0,         1'b1, 1'b0};
    vecs[14] = '{8'hFF, 1'b1, 0,  32'h0,         1'b1, 1'b0};

    rst = 1'b1; cs = 1'b0; addr = 8'h0; empty = 1'b0;
    set_fixed_regs();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset outputs", {ack, err, rd, data[28:0]} | {31'h0, |data[31:29]}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      empty = vecs[i].e;
      read_check(vecs[i].a, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_err,
                 vecs[i].exp_pop, $sformatf("vec%0d", i));
    end

    // CS raised again during RELEASE: ignored there, so ack arrives one cycle later.
    empty = 1'b0;
    read_check(8'h5C, 10, 32'hCAFE_F00D, 1'b0, 1'b1, "held");
    cs = 1'b1; addr = 8'h18;
    begin
      int lat;
      lat = 0;
      do begin @(posedge sys_clk); #1; lat++; end while (ack !== 1'b1 && lat < 10);
      chk("post_release latency", lat, 3);
      chk("post_release data", data, 32'hA5A5_0003);
      cs = 1'b0;
      @(posedge sys_clk); #1;
      chk("post_release clear", {31'h0, ack}, 32'h0);
    end

    // CS dropped during SELECT: transaction completes, ACK lasts one cycle, pop fires.
    begin
      int p0;
      @(posedge sys_clk); #1;
      cs = 1'b1; addr = 8'h5C; p0 = pop_cnt;
      @(posedge sys_clk); #1;
      cs = 1'b0;
      @(posedge sys_clk); #1;
      chk("early_drop ack", {31'h0, ack}, 32'h1);
      chk("early_drop data", data, 32'hCAFE_F00D);
      chk("early_drop rd", {31'h0, rd}, 32'h1);
      @(posedge sys_clk); #1;
      chk("early_drop clear", {31'h0, ack}, 32'h0);
      chk("early_drop pops", pop_cnt - p0, 32'h1);
    end

    // Reset in the SELECT cycle of a popping read.
    begin
      int p0;
      @(posedge sys_clk); #1;
      @(posedge sys_clk); #1;
      cs = 1'b1; addr = 8'h5C; p0 = pop_cnt;
      @(posedge sys_clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_sel ack", {31'h0, ack}, 32'h0);
      @(posedge sys_clk); #1;
      chk("rst_sel outputs", {ack, err, rd, data[28:0]} | {31'h0, |data[31:29]}, 32'h0);
      cs = 1'b0;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      chk("rst_sel pops", pop_cnt - p0, 32'h0);
      read_check(8'h5C, 0, 32'hCAFE_F00D, 1'b0, 1'b1, "after_rst");
    end

    // Randomized reads against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  a;
      logic [32:0] ref_v;
      logic        pop;
      for (int r = 0; r < 8; r++) regs[r] = $urandom;
      empty = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? map_addr[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      ref_v = ref_read(a, empty);
      pop = (a == 8'h5C) && !empty;
      read_check(a, $urandom_range(0, 3), ref_v[31:0], ref_v[32], pop, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
